// File: rtl/bsg_round_robin_1_to_n_pkg.sv
// Shared helpers for the buffered 1-to-N round-robin demultiplexer:
// tag width derivation and wrap-around pointer increment.
package bsg_round_robin_1_to_n_pkg;

    function automatic int tag_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_inc(input int p, input int limit);
        return (p >= limit - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/bsg_rr_1_to_n_chan_fifo.sv
// One output channel buffer: els_p-entry FIFO with push/pop, full/empty and head.
// Illegal pushes (full) and pops (empty) are ignored.
module bsg_rr_1_to_n_chan_fifo
    import bsg_round_robin_1_to_n_pkg::*;
#(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] data_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w-1:0]   rd_r;
    logic [ptr_w-1:0]   wr_r;
    logic [cnt_w-1:0]   cnt_r;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (cnt_r == cnt_w'(els_p));
    assign empty_o = (cnt_r == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_r[rd_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_r  <= '0;
            wr_r  <= '0;
            cnt_r <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_r[wr_r] <= data_i;
                wr_r        <= ptr_w'(ptr_inc(int'(wr_r), els_p));
            end
            if (pop_ok) begin
                rd_r <= ptr_w'(ptr_inc(int'(rd_r), els_p));
            end
            // push+pop together leaves the count unchanged
            if (push_ok && !pop_ok) begin
                cnt_r <= cnt_r + cnt_w'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_r <= cnt_r - cnt_w'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_round_robin_1_to_n_buffered.sv
// Steers one tagged valid/yumi stream into num_out_p buffered output channels.
// Optional bad-tag drop/err_o logic is enabled by BSG_ROUND_ROBIN_1_TO_N_TAG_CHECK_EN.
module bsg_round_robin_1_to_n_buffered
    import bsg_round_robin_1_to_n_pkg::*;
#(
    parameter int  width_p      = 16,
    parameter int  num_out_p    = 2,
    parameter int  strict_p     = 0,
    parameter int  els_p        = 2,
    localparam int tag_width_lp = tag_width(num_out_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    input  logic [tag_width_lp-1:0]      tag_i,
    output logic                         yumi_o,
    output logic [num_out_p-1:0]         v_o,
    output logic [num_out_p*width_p-1:0] data_o,
    input  logic [num_out_p-1:0]         yumi_i,
    output logic                         err_o
);

    logic [tag_width_lp-1:0] rr_r;
    logic [tag_width_lp-1:0] dest;
    logic                    dest_in_range;
    logic                    dest_full;
    logic                    accept;
    logic [num_out_p-1:0]    push;
    logic [num_out_p-1:0]    full;
    logic [num_out_p-1:0]    empty;
    logic [width_p-1:0]      head [num_out_p];

    assign dest          = (strict_p != 0) ? rr_r : tag_i;
    assign dest_in_range = (32'(dest) < num_out_p);

    // Decoded lookup keeps an out-of-range tag from indexing past the vector
    always_comb begin
        dest_full = 1'b0;
        for (int k = 0; k < num_out_p; k++) begin
            if (dest == tag_width_lp'(k)) begin
                dest_full = full[k];
            end
        end
    end

`ifdef BSG_ROUND_ROBIN_1_TO_N_TAG_CHECK_EN
    logic err_r;

    // Out-of-range words are swallowed so a bad tag cannot wedge the link
    assign yumi_o = reset_n_i & v_i & (~dest_in_range | ~dest_full);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if (v_i && !dest_in_range) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    assign yumi_o = reset_n_i & v_i & dest_in_range & ~dest_full;
    assign err_o  = 1'b0;
`endif

    assign accept = yumi_o & dest_in_range;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r <= '0;
        end else if ((strict_p != 0) && accept) begin
            rr_r <= tag_width_lp'(ptr_inc(int'(rr_r), num_out_p));
        end
    end

    for (genvar k = 0; k < num_out_p; k++) begin : g_chan
        assign push[k] = accept & (dest == tag_width_lp'(k));

        bsg_rr_1_to_n_chan_fifo #(
            .width_p (width_p),
            .els_p   (els_p)
        ) u_fifo (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .push_i    (push[k]),
            .data_i    (data_i),
            .pop_i     (yumi_i[k]),
            .full_o    (full[k]),
            .empty_o   (empty[k]),
            .data_o    (head[k])
        );

        assign v_o[k]                        = ~empty[k];
        assign data_o[k*width_p +: width_p]  = head[k];
    end

endmodule

// File: tb/tb_bsg_round_robin_1_to_n_buffered.sv
// Bench for bsg_round_robin_1_to_n_buffered: three instances (tag routing 2ch,
// strict 3ch, tag routing 3ch with bad tags) checked against a queue model.
module tb_bsg_round_robin_1_to_n_buffered;

`ifdef BSG_ROUND_ROBIN_1_TO_N_TAG_CHECK_EN
    localparam bit TAGCHK = 1'b1;
`else
    localparam bit TAGCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v_in [3];
    logic [15:0] d_in [3];
    logic [1:0]  t_in [3];
    logic [2:0]  y_in [3];

    logic        ya, yb, yc, ea, eb, ec;
    logic [1:0]  voa;
    logic [2:0]  vob, voc;
    logic [31:0] doa;
    logic [47:0] dob, doc;

    logic        yo [3];
    logic [2:0]  vo [3];
    logic [47:0] dq [3];
    logic        eo [3];

    always_comb begin
        yo[0] = ya;  yo[1] = yb;  yo[2] = yc;
        eo[0] = ea;  eo[1] = eb;  eo[2] = ec;
        vo[0] = {1'b0, voa};  vo[1] = vob;  vo[2] = voc;
        dq[0] = {16'h0, doa}; dq[1] = dob;  dq[2] = doc;
    end

    bsg_round_robin_1_to_n_buffered #(.width_p(16), .num_out_p(2), .strict_p(0), .els_p(2)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[0]), .data_i(d_in[0]), .tag_i(t_in[0][0]),
        .yumi_o(ya), .v_o(voa), .data_o(doa), .yumi_i(y_in[0][1:0]), .err_o(ea));

    bsg_round_robin_1_to_n_buffered #(.width_p(16), .num_out_p(3), .strict_p(1), .els_p(2)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[1]), .data_i(d_in[1]), .tag_i(t_in[1]),
        .yumi_o(yb), .v_o(vob), .data_o(dob), .yumi_i(y_in[1]), .err_o(eb));

    bsg_round_robin_1_to_n_buffered #(.width_p(16), .num_out_p(3), .strict_p(0), .els_p(2)) dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[2]), .data_i(d_in[2]), .tag_i(t_in[2]),
        .yumi_o(yc), .v_o(voc), .data_o(doc), .yumi_i(y_in[2]), .err_o(ec));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: one queue per channel, capacity 2, plus rr pointer and sticky error
    int          nout   [3] = '{2, 3, 3};
    bit          strict [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mq [3][3][$];
    int          rr_m   [3];
    bit          err_m  [3];

    initial begin
        int dest;
        bit ok, bad, ev;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    for (int k = 0; k < 3; k++) mq[i][k].delete();
                    rr_m[i]  = 0;
                    err_m[i] = 1'b0;
                    chk($sformatf("rst_v_o%0d", i), vo[i], 0);
                    chk($sformatf("rst_yumi_o%0d", i), yo[i], 0);
                    chk($sformatf("rst_err_o%0d", i), eo[i], 0);
                    chk($sformatf("rst_data_o%0d", i), dq[i], 0);
                end else begin
                    for (int k = 0; k < nout[i]; k++) begin
                        ev = (mq[i][k].size() != 0);
                        chk($sformatf("v_o%0d_ch%0d", i, k), vo[i][k], ev);
                        if (ev) chk($sformatf("data_o%0d_ch%0d", i, k), dq[i][k*16 +: 16], mq[i][k][0]);
                    end
                    chk($sformatf("err_o%0d", i), eo[i], err_m[i]);
                    dest = strict[i] ? rr_m[i] : int'(t_in[i]);
                    bad  = v_in[i] && (dest >= nout[i]);
                    ok   = 1'b0;
                    if (v_in[i] && dest < nout[i]) ok = (mq[i][dest].size() < 2);
                    chk($sformatf("yumi_o%0d", i), yo[i], ok || (TAGCHK && bad));
                    for (int k = 0; k < nout[i]; k++) begin
                        if (y_in[i][k] && mq[i][k].size() > 0) void'(mq[i][k].pop_front());
                    end
                    if (ok) begin
                        mq[i][dest].push_back(d_in[i]);
                        if (strict[i]) rr_m[i] = (rr_m[i] + 1) % nout[i];
                    end
                    if (TAGCHK && bad) err_m[i] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v_in[i] = 1'b0; d_in[i] = '0; t_in[i] = '0; y_in[i] = '0;
        end
        v_in[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_v_a", voa, 2'b00);
        chk("reset_data_a", doa, 32'h0);
        chk("reset_yumi_a", ya, 1'b0);

        // tag routing, first cycle after reset
        step();
        rst_n = 1'b1; d_in[0] = 16'h1111; t_in[0] = 2'd1;
        #1 chk("first_accept", ya, 1'b1);
        step();
        v_in[0] = 1'b0;
        #1 chk("route_v_o", voa, 2'b10);
        chk("route_data", doa[31:16], 16'h1111);
        y_in[0] = 3'b010;
        step();
        y_in[0] = 3'b000;

        // backpressure on channel 0
        v_in[0] = 1'b1; t_in[0] = 2'd0; d_in[0] = 16'h000A;
        step();
        d_in[0] = 16'h000B;
        step();
        d_in[0] = 16'h000C;
        #1 chk("bp_full", ya, 1'b0);
        step();
        #1 chk("bp_still_full", ya, 1'b0);
        y_in[0] = 3'b001;
        #1 chk("bp_no_passthru", ya, 1'b0);
        chk("bp_head_a", doa[15:0], 16'h000A);
        step();
        y_in[0] = 3'b000;
        #1 chk("bp_resume", ya, 1'b1);
        step();
        v_in[0] = 1'b0;
        #1 chk("bp_head_b", doa[15:0], 16'h000B);
        y_in[0] = 3'b001;
        step();
        #1 chk("bp_head_c", doa[15:0], 16'h000C);
        step();
        y_in[0] = 3'b000;

        // simultaneous push and pop on channel 1
        v_in[0] = 1'b1; t_in[0] = 2'd1; d_in[0] = 16'h0101;
        step();
        d_in[0] = 16'h0202;
        step();
        d_in[0] = 16'h0303; y_in[0] = 3'b010;
        #1 chk("pp_full_no_accept", ya, 1'b0);
        step();
        #1 chk("pp_accept_after_pop", ya, 1'b1);
        step();
        v_in[0] = 1'b0; y_in[0] = 3'b000;
        #1 chk("pp_v_o", voa[1], 1'b1);
        chk("pp_head", doa[31:16], 16'h0303);
        y_in[0] = 3'b010;
        step();
        y_in[0] = 3'b000;
        #1 chk("pp_count_one", voa, 2'b00);

        // strict round robin, tags ignored
        v_in[1] = 1'b1;
        t_in[1] = 2'd3; d_in[1] = 16'd1; step();
        t_in[1] = 2'd0; d_in[1] = 16'd2; step();
        t_in[1] = 2'd2; d_in[1] = 16'd3; step();
        t_in[1] = 2'd1; d_in[1] = 16'd4; step();
        v_in[1] = 1'b0;
        #1 chk("strict_v_o", vob, 3'b111);
        chk("strict_heads", dob, {16'd3, 16'd2, 16'd1});
        v_in[1] = 1'b1; d_in[1] = 16'd5; step();
        d_in[1] = 16'd6; step();
        v_in[1] = 1'b0; y_in[1] = 3'b101;
        step();
        #1 chk("strict_wrap_head", dob[15:0], 16'd4);
        step();
        y_in[1] = 3'b000; v_in[1] = 1'b1; d_in[1] = 16'd7;
        step();
        d_in[1] = 16'd8;
        #1 chk("strict_no_skip", yb, 1'b0);
        chk("strict_stall_v_o", vob, 3'b011);
        step();
        #1 chk("strict_still_stall", yb, 1'b0);
        y_in[1] = 3'b010;
        #1 chk("strict_no_passthru", yb, 1'b0);
        step();
        y_in[1] = 3'b000;
        #1 chk("strict_resume", yb, 1'b1);
        step();
        v_in[1] = 1'b0; y_in[1] = 3'b111;
        step();
        step();
        y_in[1] = 3'b000;
        #1 chk("strict_drained", vob, 3'b000);

        // out-of-range tag on the 3-channel tag-routed instance
        v_in[2] = 1'b1; t_in[2] = 2'd3; d_in[2] = 16'hDEAD;
`ifdef BSG_ROUND_ROBIN_1_TO_N_TAG_CHECK_EN
        #1 chk("bad_tag_consumed", yc, 1'b1);
        step();
        v_in[2] = 1'b0;
        #1 chk("bad_tag_err", ec, 1'b1);
        chk("bad_tag_no_v_o", voc, 3'b000);
        step();
        #1 chk("bad_tag_err_sticky", ec, 1'b1);
`else
        #1 chk("bad_tag_stall", yc, 1'b0);
        step();
        #1 chk("bad_tag_still_stall", yc, 1'b0);
        chk("bad_tag_no_v_o", voc, 3'b000);
        chk("bad_tag_err_tied", ec, 1'b0);
        v_in[2] = 1'b0;
        step();
`endif
        v_in[2] = 1'b1; t_in[2] = 2'd2; d_in[2] = 16'h2222;
        step();
        v_in[2] = 1'b0;
        #1 chk("c_ch2_v_o", voc, 3'b100);
        chk("c_ch2_data", doc[47:32], 16'h2222);

        // async reset with words buffered
        v_in[0] = 1'b1; t_in[0] = 2'd0; d_in[0] = 16'h0E01;
        step();
        d_in[0] = 16'h0E02;
        step();
        t_in[0] = 2'd1; d_in[0] = 16'h0E03;
        #1 chk("pre_reset_yumi", ya, 1'b1);
        chk("pre_reset_v_o", voa, 2'b01);
        rst_n = 1'b0;
        #1 chk("async_v_o_a", voa, 2'b00);
        chk("async_yumi_a", ya, 1'b0);
        chk("async_data_a", doa, 32'h0);
        chk("async_v_o_c", voc, 3'b000);
        chk("async_err_c", ec, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1 chk("post_reset_accept", ya, 1'b1);
        step();
        v_in[0] = 1'b0;
        #1 chk("post_reset_route", voa, 2'b10);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_round_robin_1_to_n_buffered.md
# bsg_round_robin_1_to_n_buffered

Receive-side counterpart of the round-robin N-to-1 arbiter. Consumes one tagged valid/yumi stream, either the arbiter's `v_o`/`data_o`/`tag_o` or a link carrying it, and steers each word to one of `num_out_p` output channels. Each output channel has a small FIFO. Routing is by incoming tag, or by a strict internal round-robin pointer that mirrors the arbiter's strict mode. It sits at the far end of a shared channel and restores per-source streams.

## Interface
Parameters:
- `width_p`, 16, data width per word
- `num_out_p`, 2, number of output channels, ≥2
- `strict_p`, 0, routing mode:
  - 0: route by `tag_i`
  - 1: route by internal round-robin pointer; `tag_i` ignored
- `els_p`, 2, FIFO depth per output; power of 2, ≥2
- `tag_width_lp`, derived: `$clog2(num_out_p)`, minimum 1

Ports:
- `clk_i`  in  1  clock; all state on rising edge
- `reset_n_i`  in  1  reset, asynchronous, active-low
- `v_i`  in  1  input word valid
- `data_i`  in  `width_p`  input word
- `tag_i`  in  `tag_width_lp`  destination channel (`strict_p`=0 only)
- `yumi_o`  out  1  input word consumed this cycle
- `v_o`  out  `num_out_p`  per-channel valid
- `data_o`  out  `num_out_p*width_p`  per-channel head word; channel k at bits [k*width_p +: width_p]
- `yumi_i`  in  `num_out_p`  per-channel consume
- `err_o`  out  1  sticky bad-tag flag

## Operation
- **Destination selection.** dest = `tag_i` when `strict_p`=0, else `rr_r`.
- **Input accept.**
  - `yumi_o` = `v_i` & FIFO[dest] not full & dest in range & `reset_n_i`.
  - `yumi_o` never depends on any `yumi_i`. There is no full-FIFO pass-through.
- **On accept.**
  - `data_i` is written at the tail of FIFO[dest].
  - If `strict_p`=1, `rr_r` advances to `rr_r+1`, wrapping from `num_out_p-1` to 0.
- **Strict mode does not skip.** When FIFO[`rr_r`] is full, input stalls even if other FIFOs have space.
- **Output side.**
  - `v_o[k]` = FIFO[k] count ≠ 0.
  - `data_o[k]` = FIFO[k] head.
  - `yumi_i[k]` pops FIFO[k].
  - `yumi_i[k]` while `v_o[k]`=0 is a protocol error and is ignored; no pointer moves.
- **FIFO bookkeeping.** Each FIFO keeps read pointer, write pointer and count (0..`els_p`).
  - Pointers wrap modulo `els_p`.
  - Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
  - Push is legal only when not full. Pop is legal only when not empty.
- **Out-of-range tag.** Applies only when `num_out_p` is not a power of 2; see Configuration.
- **Reset.** `reset_n_i` low asynchronously clears all counts, pointers, storage, `rr_r` and `err_o`. Reset mid-transfer discards all buffered words.

## Timing
- Reset values:
  - `v_o`=0, `data_o`=0, `err_o`=0.
  - `yumi_o`=0 while `reset_n_i` is low.
- Latency: word accepted in cycle t appears on `v_o`/`data_o` in cycle t+1. There is no same-cycle bypass.
- Throughput: one word per cycle per channel when the consumer pops every cycle. This holds for `els_p`≥2.
- `yumi_o` is combinational from `v_i`, `tag_i` and registered state only.
- First cycle after reset deasserts: `yumi_o`=`v_i`, since all FIFOs are empty.

## Configuration
- Macro: `BSG_ROUND_ROBIN_1_TO_N_TAG_CHECK_EN`.
- **Defined.** A valid word whose tag is ≥`num_out_p` (`strict_p`=0):
  - is consumed (`yumi_o`=1) and dropped; no FIFO changes;
  - sets `err_o` to 1, held until reset.
- **Undefined.**
  - Such a word is never accepted (`yumi_o`=0) and stalls the input.
  - `err_o` is tied 0.
  - There is no tag-check logic.

## Structure
- Package `bsg_round_robin_1_to_n_pkg` holds:
  - the tag-width function;
  - the pointer-increment-with-wrap function.
- Sub-module `bsg_rr_1_to_n_chan_fifo`:
  - one `els_p`-entry FIFO with push, pop, full, empty and head outputs;
  - instantiated `num_out_p` times.
- Top level holds dest selection, `rr_r`, the accept/steering logic, and the optional tag-check/`err_o` logic.

## Test plan
- **Reset then tag routing.** `strict_p`=0, `num_out_p`=2: `v_i`=1, `data_i`=0x1111, `tag_i`=1, all `yumi_i`=0.
  - `yumi_o`=1 in the accept cycle.
  - Next cycle `v_o`=2'b10, `data_o[31:16]`=0x1111.
  - `v_o[0]` stays 0.
- **Backpressure.** `els_p`=2, `yumi_i`=0: push 0xA, 0xB, 0xC to channel 0.
  - First two accepted.
  - Third sees `yumi_o`=0 until `yumi_i[0]` pops 0xA.
  - Output order is 0xA, 0xB, 0xC.
- **Strict mode.** `strict_p`=1, `num_out_p`=3: push 1, 2, 3, 4 with arbitrary tags.
  - Data lands in channels 0, 1, 2, 0.
  - `rr_r` wraps 2→0.
  - With channel 1 full, the next word stalls although channel 2 is empty.
- **Simultaneous push and pop.** Full channel 0 (count=2), `yumi_i[0]`=1, `v_i`=1 to channel 0.
  - `yumi_o`=0 and the count drops to 1.
  - Next cycle the word is accepted; the count stays 1 during a push+pop cycle.
- **Bad tag.** `num_out_p`=3, `tag_i`=3, `v_i`=1.
  - With the macro: `yumi_o`=1, no `v_o` change, `err_o` becomes 1 the next cycle and stays set.
  - Without the macro: `yumi_o` stays 0.
- **Async reset mid-stream.** Assert `reset_n_i`=0 with 2 words buffered.
  - `v_o`=0, `yumi_o`=0 and `err_o`=0 immediately, without waiting for a clock edge.
